// File: rtl/kw_transpose_stream_pkg.sv
// Shared definitions for the streaming corner-turn buffer.
//   NUM_BANKS  : number of ping-pong tile banks
//   bank_idx_t : selects one of the two banks
//   clog2_min1 : counter width helper, never returns less than 1 bit
package kw_transpose_pkg;

  localparam int NUM_BANKS = 2;

  typedef logic bank_idx_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/kw_transpose_stream_wrap_counter.sv
// Modulo-MAX up-counter.
//   clk, rst : clock, async active-high reset (count returns to 0)
//   en_i     : advance by one this cycle
//   cnt_o    : current count, 0..MAX-1
//   wrap_o   : en_i while the count sits at MAX-1 (count returns to 0 next)
module kw_wrap_counter
  import kw_transpose_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = clog2_min1(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/kw_transpose_stream.sv
// Streaming corner-turn buffer: takes a ROWS x COLS tile one row per beat and
// returns it one column per beat, using two ping-pong banks so one tile can
// fill while the previous one drains.
//   clk, rst            : clock, async active-high reset (drops all tiles)
//   in_valid/in_ready   : row handshake, in_data[c] = element (row, c)
//   out_valid/out_ready : column handshake, out_data[r] = element (r, col)
//   out_last            : marks the final column of each tile
module kw_transpose_stream
  import kw_transpose_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [COLS-1:0][DATA_WIDTH-1:0]  in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ROWS-1:0][DATA_WIDTH-1:0]  out_data,
  output logic                             out_last
);

  localparam int RW = clog2_min1(ROWS);
  localparam int CW = clog2_min1(COLS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic [NUM_BANKS-1:0][ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] mem_q;

  logic [NUM_BANKS-1:0] bank_full_q, bank_full_d;
  bank_idx_t            wr_bank_q, wr_bank_d;
  bank_idx_t            rd_bank_q, rd_bank_d;

  logic          wr_en, rd_en;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic          row_wrap, col_wrap;

  // Handshake flags depend on state only, so neither side sees a
  // combinational path from the other side's valid/ready.
  assign in_ready  = !bank_full_q[wr_bank_q];
  assign out_valid = bank_full_q[rd_bank_q];
  assign out_last  = out_valid && (col_cnt == COL_LAST);

  assign wr_en = in_valid && in_ready;
  assign rd_en = out_valid && out_ready;

  kw_wrap_counter #(.MAX(ROWS), .W(RW)) u_row_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (wr_en),
    .cnt_o (row_cnt),
    .wrap_o(row_wrap)
  );

  kw_wrap_counter #(.MAX(COLS), .W(CW)) u_col_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (rd_en),
    .cnt_o (col_cnt),
    .wrap_o(col_wrap)
  );

  // Fill and drain completing together always touch different banks
  // (write bank must be empty, read bank must be full), so both apply.
  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    if (row_wrap) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = ~wr_bank_q;
    end
    if (col_wrap) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end
  end

  // Column select straight from the registered tile; never from in_data.
  always_comb begin
    out_data = '0;
    for (int r = 0; r < ROWS; r++) out_data[r] = mem_q[rd_bank_q][r][col_cnt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        mem_q <= '0;
    else if (wr_en) mem_q[wr_bank_q][row_cnt] <= in_data;
  end

endmodule

// File: tb/tb_kw_transpose_stream.sv
module tb_kw_transpose_stream;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: 2x3x8   B: 4x4x8   C: 3x5x8   D: 1x1x16
  logic a_iv, a_ir, a_ov, a_or, a_ol;
  logic [2:0][7:0] a_id;
  logic [1:0][7:0] a_od;
  logic b_iv, b_ir, b_ov, b_or, b_ol;
  logic [3:0][7:0] b_id, b_od;
  logic c_iv, c_ir, c_ov, c_or, c_ol;
  logic [4:0][7:0] c_id;
  logic [2:0][7:0] c_od;
  logic d_iv, d_ir, d_ov, d_or, d_ol;
  logic [0:0][15:0] d_id, d_od;

  kw_transpose_stream #(.ROWS(2), .COLS(3), .DATA_WIDTH(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_last(a_ol));
  kw_transpose_stream #(.ROWS(4), .COLS(4), .DATA_WIDTH(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_last(b_ol));
  kw_transpose_stream #(.ROWS(3), .COLS(5), .DATA_WIDTH(8)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_last(c_ol));
  kw_transpose_stream #(.ROWS(1), .COLS(1), .DATA_WIDTH(16)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id),
    .out_valid(d_ov), .out_ready(d_or), .out_data(d_od), .out_last(d_ol));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_iv = 0; a_or = 0; a_id = '0;
    b_iv = 0; b_or = 0; b_id = '0;
    c_iv = 0; c_or = 0; c_id = '0;
    d_iv = 0; d_or = 0; d_id = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed cycle table for the 2x3 instance.
  typedef struct {
    logic        iv;
    logic [23:0] id;
    logic        ordy;
    logic        e_ir, e_ov, e_ol, chkd;
    logic [15:0] e_od;
  } vec_a_t;
  vec_a_t tab_a[$];

  // Golden transpose helper for the 4x4 instance.
  logic [3:0][7:0] bt[32];
  function automatic logic [31:0] col_b(input int base, input int c);
    logic [3:0][7:0] v;
    for (int r = 0; r < 4; r++) v[r] = bt[base + r][c];
    return v;
  endfunction

  // Reference model for the random 3x5 run: tiles as queued columns.
  typedef logic [2:0][7:0] col_c_t;
  col_c_t          expq[$];
  logic [4:0][7:0] part_c[3];
  int pr, full_tiles, oc, rows_sent, cols_got, dut_fire, got, dut_beats;
  logic e_ir, e_ov, in_fire, out_fire;
  logic [15:0] dv[8];

  initial begin
    // reset state of every instance, checked while rst is high
    a_iv = 0; a_or = 0; a_id = '0; b_iv = 0; b_or = 0; b_id = '0;
    c_iv = 0; c_or = 0; c_id = '0; d_iv = 0; d_or = 0; d_id = '0;
    rst = 1'b1;
    step();
    chk("rst_a", {a_ir, a_ov, a_ol, 16'(a_od)}, {1'b1, 1'b0, 1'b0, 16'h0});
    chk("rst_b", {b_ir, b_ov, b_ol, 32'(b_od)}, {1'b1, 1'b0, 1'b0, 32'h0});
    chk("rst_c", {c_ir, c_ov, c_ol, 24'(c_od)}, {1'b1, 1'b0, 1'b0, 24'h0});
    chk("rst_d", {d_ir, d_ov, d_ol, 16'(d_od)}, {1'b1, 1'b0, 1'b0, 16'h0});
    @(negedge clk);
    rst = 1'b0;

    // ---- 2x3 table: basic transpose, latency, stall stability ----
    tab_a.push_back('{1, 24'h030201, 1, 1, 0, 0, 1, 16'h0000});
    tab_a.push_back('{1, 24'h131211, 1, 1, 0, 0, 0, 16'h0000});
    tab_a.push_back('{0, 24'h000000, 1, 1, 1, 0, 1, 16'h1101});
    tab_a.push_back('{0, 24'h000000, 1, 1, 1, 0, 1, 16'h1202});
    tab_a.push_back('{0, 24'h000000, 1, 1, 1, 1, 1, 16'h1303});
    tab_a.push_back('{1, 24'h232221, 0, 1, 0, 0, 0, 16'h0000});
    tab_a.push_back('{1, 24'h333231, 0, 1, 0, 0, 0, 16'h0000});
    tab_a.push_back('{0, 24'h000000, 0, 1, 1, 0, 1, 16'h3121});
    tab_a.push_back('{0, 24'h000000, 0, 1, 1, 0, 1, 16'h3121});
    tab_a.push_back('{0, 24'h000000, 1, 1, 1, 0, 1, 16'h3121});
    tab_a.push_back('{0, 24'h000000, 1, 1, 1, 0, 1, 16'h3222});
    tab_a.push_back('{0, 24'h000000, 1, 1, 1, 1, 1, 16'h3323});
    tab_a.push_back('{0, 24'h000000, 1, 1, 0, 0, 0, 16'h0000});
    for (int i = 0; i < tab_a.size(); i++) begin
      a_iv = tab_a[i].iv; a_id = tab_a[i].id; a_or = tab_a[i].ordy;
      chk($sformatf("a_in_ready[%0d]", i), a_ir, tab_a[i].e_ir);
      chk($sformatf("a_out_valid[%0d]", i), a_ov, tab_a[i].e_ov);
      chk($sformatf("a_out_last[%0d]", i), a_ol, tab_a[i].e_ol);
      if (tab_a[i].chkd) chk($sformatf("a_out_data[%0d]", i), a_od, tab_a[i].e_od);
      step();
    end

    // ---- 4x4 sustained throughput, 5 tiles ----
    do_reset();
    for (int i = 0; i < 20; i++) bt[i] = 32'($urandom);
    got = 0; dut_beats = 0;
    for (int cyc = 0; cyc < 28; cyc++) begin
      b_iv = (cyc < 20);
      b_id = (cyc < 20) ? bt[cyc] : '0;
      b_or = 1'b1;
      chk("b_tput_in_ready", b_ir, 1'b1);
      if (cyc >= 4 && cyc < 24) begin
        chk("b_tput_out_valid", b_ov, 1'b1);
        chk("b_tput_out_data", b_od, col_b((got / 4) * 4, got % 4));
        chk("b_tput_out_last", b_ol, (got % 4) == 3);
        got++;
      end else begin
        chk("b_tput_idle_valid", b_ov, 1'b0);
      end
      if (b_ov && b_or) dut_beats++;
      step();
    end
    chk("b_tput_beats", dut_beats, 20);

    // ---- 4x4 both banks full, then release ----
    do_reset();
    for (int i = 0; i < 9; i++) bt[i] = 32'($urandom);
    b_or = 1'b0;
    for (int k = 0; k < 9; k++) begin
      b_iv = 1'b1; b_id = bt[k];
      chk("b_full_in_ready", b_ir, k < 8);
      if (k >= 4) begin
        chk("b_full_out_valid", b_ov, 1'b1);
        chk("b_full_hold_col0", b_od, col_b(0, 0));
      end
      step();
    end
    b_or = 1'b1;
    chk("b_pulse_data", b_od, col_b(0, 0));
    chk("b_pulse_in_ready", b_ir, 1'b0);
    step();
    b_or = 1'b0;
    chk("b_pulse_adv", b_od, col_b(0, 1));
    chk("b_pulse_in_ready2", b_ir, 1'b0);
    chk("b_pulse_last", b_ol, 1'b0);
    step();
    chk("b_stall_stable", b_od, col_b(0, 1));
    b_or = 1'b1;
    for (int c = 1; c < 4; c++) begin
      chk("b_drain_in_ready", b_ir, 1'b0);
      chk("b_drain_data", b_od, col_b(0, c));
      chk("b_drain_last", b_ol, c == 3);
      step();
    end
    chk("b_release_in_ready", b_ir, 1'b1);
    chk("b_release_tile1", b_od, col_b(4, 0));
    chk("b_release_valid", b_ov, 1'b1);
    step();
    b_iv = 1'b0;

    // ---- 4x4 mid-operation reset ----
    do_reset();
    for (int i = 0; i < 12; i++) bt[i] = 32'($urandom);
    b_or = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b_iv = 1'b1; b_id = bt[k];
      step();
    end
    b_iv = 1'b0;
    chk("b_mid_valid", b_ov, 1'b1);
    chk("b_mid_col2", b_od, col_b(0, 2));
    rst = 1'b1;
    #1;
    chk("b_rst_valid", b_ov, 1'b0);
    chk("b_rst_last", b_ol, 1'b0);
    chk("b_rst_data", b_od, 32'h0);
    chk("b_rst_in_ready", b_ir, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      b_iv = (k < 4);
      b_id = (k < 4) ? bt[8 + k] : '0;
      if (k >= 4) begin
        chk("b_fresh_valid", b_ov, 1'b1);
        chk("b_fresh_data", b_od, col_b(8, k - 4));
        chk("b_fresh_last", b_ol, k == 7);
      end else begin
        chk("b_fresh_empty", b_ov, 1'b0);
      end
      step();
    end

    // ---- 1x1x16 ----
    do_reset();
    for (int k = 0; k < 8; k++) dv[k] = (k % 2 == 0) ? 16'hBEEF : 16'($urandom);
    for (int k = 0; k < 8; k++) begin
      d_iv = 1'b1; d_id = dv[k]; d_or = 1'b1;
      chk("d_in_ready", d_ir, 1'b1);
      if (k > 0) begin
        chk("d_out_valid", d_ov, 1'b1);
        chk("d_out_data", d_od, dv[k - 1]);
        chk("d_out_last", d_ol, 1'b1);
      end else begin
        chk("d_first_valid", d_ov, 1'b0);
      end
      step();
    end
    d_iv = 1'b0;

    // ---- 3x5 random traffic against the tile-level model ----
    do_reset();
    pr = 0; full_tiles = 0; oc = 0; rows_sent = 0; cols_got = 0; dut_fire = 0;
    for (int cyc = 0; cyc < 20000 && cols_got < 1000; cyc++) begin
      c_iv = (rows_sent < 600) && ($urandom_range(0, 1) == 1);
      for (int c = 0; c < 5; c++) c_id[c] = 8'($urandom);
      c_or = ($urandom_range(0, 1) == 1);
      e_ir = (full_tiles < 2);
      e_ov = (full_tiles > 0);
      chk("c_in_ready", c_ir, e_ir);
      chk("c_out_valid", c_ov, e_ov);
      if (e_ov && expq.size() > 0) begin
        chk("c_out_data", c_od, expq[0]);
        chk("c_out_last", c_ol, oc == 4);
      end
      if (c_ov && c_or) dut_fire++;
      in_fire  = c_iv && e_ir;
      out_fire = e_ov && c_or;
      if (out_fire) begin
        void'(expq.pop_front());
        cols_got++;
        oc++;
        if (oc == 5) begin
          oc = 0;
          full_tiles--;
        end
      end
      if (in_fire) begin
        part_c[pr] = c_id;
        pr++;
        rows_sent++;
        if (pr == 3) begin
          pr = 0;
          for (int c = 0; c < 5; c++) begin
            col_c_t col;
            for (int r = 0; r < 3; r++) col[r] = part_c[r][c];
            expq.push_back(col);
          end
          full_tiles++;
        end
      end
      step();
    end
    c_iv = 1'b0; c_or = 1'b0;
    chk("c_random_done", cols_got, 1000);
    chk("c_dut_beats", dut_fire, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
